// File: rtl/tx_frame_arbiter_if.sv
// Bundle of request/grant, source stream and framer-side signals for tx_frame_arbiter.
// The slave modport is the arbiter's view; master is the sources/framer side.
interface tx_frame_arbiter_if;
   logic        arpreq,   dhcpreq,   datareq;
   logic        arpgnt,   dhcpgnt,   datagnt;
   logic        arpvalid, dhcpvalid, datavalid;
   logic        arpsof,   dhcpsof,   datasof;
   logic        arpeof,   dhcpeof,   dataeof;
   logic [15:0] arpdata,  dhcpdata,  datadata;
   logic        arpready, dhcpready, dataready;
   logic        txvalid,  txsof,     txeof;
   logic [15:0] txdata;
   logic        txready;
   logic [1:0]  txsrc;
   logic        aborterr;

   modport slave (
      input  arpreq, dhcpreq, datareq,
      input  arpvalid, dhcpvalid, datavalid,
      input  arpsof, dhcpsof, datasof,
      input  arpeof, dhcpeof, dataeof,
      input  arpdata, dhcpdata, datadata,
      input  txready,
      output arpgnt, dhcpgnt, datagnt,
      output arpready, dhcpready, dataready,
      output txvalid, txsof, txeof, txdata,
      output txsrc, aborterr
   );

   modport master (
      output arpreq, dhcpreq, datareq,
      output arpvalid, dhcpvalid, datavalid,
      output arpsof, dhcpsof, datasof,
      output arpeof, dhcpeof, dataeof,
      output arpdata, dhcpdata, datadata,
      output txready,
      input  arpgnt, dhcpgnt, datagnt,
      input  arpready, dhcpready, dataready,
      input  txvalid, txsof, txeof, txdata,
      input  txsrc, aborterr
   );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Whole-frame arbiter sharing the Ethernet TX framing path between ARP, DHCP and UDP data.
// Grants one source at a time, forwards its stream unbuffered, then holds an inter-frame gap.
module tx_frame_arbiter #(
   parameter int IFG        = 6,
   parameter int SOFTIMEOUT = 255,
   parameter int STARVEMAX  = 4
) (
   input logic              clock,
   input logic              reset,
   tx_frame_arbiter_if.slave bus
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAITSOF = 2'd1;
   localparam logic [1:0] ST_XFER    = 2'd2;
   localparam logic [1:0] ST_GAP     = 2'd3;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_ARP  = 2'd1;
   localparam logic [1:0] SRC_DHCP = 2'd2;
   localparam logic [1:0] SRC_DATA = 2'd3;

   localparam int          GAP_LEN    = (IFG < 1) ? 1 : IFG;
   localparam int          TMO_LEN    = (SOFTIMEOUT < 1) ? 1 : SOFTIMEOUT;
   localparam logic [15:0] GAP_LAST   = 16'(GAP_LEN - 1);
   localparam logic [15:0] TMO_LAST   = 16'(TMO_LEN - 1);
   localparam logic [3:0]  STARVE_LIM = 4'(STARVEMAX);

   // Data wins outright once it has been passed over STARVEMAX times in a row.
   function automatic logic [1:0] pick_src(input logic arp, input logic dhcp,
                                           input logic data, input logic starved);
      logic [1:0] src;
      if (data && starved)
         src = SRC_DATA;
      else if (arp)
         src = SRC_ARP;
      else if (dhcp)
         src = SRC_DHCP;
      else if (data)
         src = SRC_DATA;
      else
         src = SRC_NONE;
      return src;
   endfunction

   function automatic logic [2:0] src_to_gnt(input logic [1:0] src);
      logic [2:0] gnt;
      case (src)
         SRC_ARP:  gnt = 3'b001;
         SRC_DHCP: gnt = 3'b010;
         SRC_DATA: gnt = 3'b100;
         default:  gnt = 3'b000;
      endcase
      return gnt;
   endfunction

   logic [1:0]  state_r;
   logic [1:0]  src_r;
   logic [2:0]  gnt_r;
   logic [3:0]  starve_r;
   logic [15:0] tmo_r;
   logic [15:0] gap_r;
   logic        abort_r;

   logic        sel_valid_s, sel_sof_s, sel_eof_s;
   logic [15:0] sel_data_s;
   logic        xfer_phase_s, accept_s, any_req_s;
   logic [1:0]  win_s;
   logic [2:0]  ready_s;
   logic        txvalid_s, txsof_s, txeof_s;
   logic [15:0] txdata_s;

   // Grant mux: select the stream of the currently granted source.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_sof_s   = 1'b0;
      sel_eof_s   = 1'b0;
      sel_data_s  = 16'h0000;
      case (src_r)
         SRC_ARP: begin
            sel_valid_s = bus.arpvalid;  sel_sof_s = bus.arpsof;
            sel_eof_s   = bus.arpeof;    sel_data_s = bus.arpdata;
         end
         SRC_DHCP: begin
            sel_valid_s = bus.dhcpvalid; sel_sof_s = bus.dhcpsof;
            sel_eof_s   = bus.dhcpeof;   sel_data_s = bus.dhcpdata;
         end
         SRC_DATA: begin
            sel_valid_s = bus.datavalid; sel_sof_s = bus.datasof;
            sel_eof_s   = bus.dataeof;   sel_data_s = bus.datadata;
         end
         default: begin
            sel_valid_s = 1'b0;
         end
      endcase
   end

   assign xfer_phase_s = (state_r == ST_WAITSOF) || (state_r == ST_XFER);
   assign accept_s     = xfer_phase_s && sel_valid_s && bus.txready;
   assign any_req_s    = bus.arpreq || bus.dhcpreq || bus.datareq;
   assign win_s        = pick_src(bus.arpreq, bus.dhcpreq, bus.datareq,
                                  starve_r == STARVE_LIM);

   // Forward path: before sof only a sof beat reaches the framer, earlier beats are swallowed.
   always_comb begin
      ready_s   = 3'b000;
      txvalid_s = 1'b0;
      txsof_s   = 1'b0;
      txeof_s   = 1'b0;
      txdata_s  = 16'h0000;
      case (state_r)
         ST_WAITSOF: begin
            ready_s   = gnt_r & {3{bus.txready}};
            txvalid_s = sel_valid_s && sel_sof_s;
            txsof_s   = sel_valid_s && sel_sof_s;
            txeof_s   = sel_valid_s && sel_sof_s && sel_eof_s;
            txdata_s  = sel_data_s;
         end
         ST_XFER: begin
            ready_s   = gnt_r & {3{bus.txready}};
            txvalid_s = sel_valid_s;
            txsof_s   = 1'b0;
            txeof_s   = sel_valid_s && sel_eof_s;
            txdata_s  = sel_data_s;
         end
         default: begin
            ready_s = 3'b000;
         end
      endcase
   end

   // Arbitration FSM with SOF timeout, inter-frame gap and data starvation counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r  <= ST_IDLE;
         src_r    <= SRC_NONE;
         gnt_r    <= 3'b000;
         starve_r <= 4'd0;
         tmo_r    <= 16'd0;
         gap_r    <= 16'd0;
         abort_r  <= 1'b0;
      end else begin
         abort_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  src_r   <= win_s;
                  gnt_r   <= src_to_gnt(win_s);
                  tmo_r   <= 16'd0;
                  state_r <= ST_WAITSOF;
                  if (win_s == SRC_DATA || !bus.datareq)
                     starve_r <= 4'd0;
                  else if (starve_r != 4'hF)
                     starve_r <= starve_r + 4'd1;
                  else
                     starve_r <= starve_r;
               end else begin
                  starve_r <= 4'd0;
               end
            end
            ST_WAITSOF: begin
               if (accept_s && sel_sof_s) begin
                  tmo_r <= 16'd0;
                  if (sel_eof_s) begin
                     state_r <= ST_GAP;
                     src_r   <= SRC_NONE;
                     gnt_r   <= 3'b000;
                     gap_r   <= 16'd0;
                  end else begin
                     state_r <= ST_XFER;
                  end
               end else if (tmo_r == TMO_LAST) begin
                  abort_r <= 1'b1;
                  state_r <= ST_GAP;
                  src_r   <= SRC_NONE;
                  gnt_r   <= 3'b000;
                  gap_r   <= 16'd0;
               end else begin
                  tmo_r <= tmo_r + 16'd1;
               end
            end
            ST_XFER: begin
               if (accept_s && sel_eof_s) begin
                  state_r <= ST_GAP;
                  src_r   <= SRC_NONE;
                  gnt_r   <= 3'b000;
                  gap_r   <= 16'd0;
               end else begin
                  state_r <= ST_XFER;
               end
            end
            ST_GAP: begin
               if (gap_r == GAP_LAST) begin
                  state_r <= ST_IDLE;
                  gap_r   <= 16'd0;
               end else begin
                  gap_r <= gap_r + 16'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               src_r   <= SRC_NONE;
               gnt_r   <= 3'b000;
            end
         endcase
      end
   end

   assign bus.arpgnt    = gnt_r[0];
   assign bus.dhcpgnt   = gnt_r[1];
   assign bus.datagnt   = gnt_r[2];
   assign bus.arpready  = ready_s[0];
   assign bus.dhcpready = ready_s[1];
   assign bus.dataready = ready_s[2];
   assign bus.txvalid   = txvalid_s;
   assign bus.txsof     = txsof_s;
   assign bus.txeof     = txeof_s;
   assign bus.txdata    = txdata_s;
   assign bus.txsrc     = src_r;
   assign bus.aborterr  = abort_r;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: priority, IFG spacing, backpressure, starvation guard,
// SOF timeout recovery, single-beat frames and asynchronous reset mid-frame.
module tb_tx_frame_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   passed = 0;
   int   failed = 0;
   int   total  = 0;

   tx_frame_arbiter_if bus ();

   tx_frame_arbiter #(.IFG(6), .SOFTIMEOUT(255), .STARVEMAX(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int s, input logic v, input logic sof, input logic eof,
                        input logic [15:0] d);
      case (s)
         1: begin bus.arpvalid = v;  bus.arpsof = sof;  bus.arpeof = eof;  bus.arpdata = d;  end
         2: begin bus.dhcpvalid = v; bus.dhcpsof = sof; bus.dhcpeof = eof; bus.dhcpdata = d; end
         3: begin bus.datavalid = v; bus.datasof = sof; bus.dataeof = eof; bus.datadata = d; end
         default: ;
      endcase
   endtask

   task automatic wait_grant(input logic [1:0] exp, input string tag);
      int n = 0;
      while (bus.txsrc == 2'd0 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.txsrc), 32'(exp));
   endtask

   task automatic single(input int s, input logic [15:0] d, input string tag);
      bus.txready = 1'b1;
      drive(s, 1'b1, 1'b1, 1'b1, d);
      #1;
      chk({tag, "_valid"}, 32'(bus.txvalid), 32'd1);
      chk({tag, "_sofeof"}, 32'({bus.txsof, bus.txeof}), 32'd3);
      chk({tag, "_data"}, 32'(bus.txdata), 32'(d));
      tick();
      drive(s, 1'b0, 1'b0, 1'b0, 16'h0000);
      chk({tag, "_gap"}, 32'(bus.txsrc), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok, mirror_ok, order_ok;
      int   sent, cyc;

      bus.arpreq = 1'b0; bus.dhcpreq = 1'b0; bus.datareq = 1'b0;
      drive(1, 1'b0, 1'b0, 1'b0, 16'h0000);
      drive(2, 1'b0, 1'b0, 1'b0, 16'h0000);
      drive(3, 1'b0, 1'b0, 1'b0, 16'h0000);
      bus.txready = 1'b1;
      bus.arpreq  = 1'b1;
      bus.datareq = 1'b1;
      #2;
      chk("rst_txsrc", 32'(bus.txsrc), 32'd0);
      chk("rst_gnt", 32'({bus.arpgnt, bus.dhcpgnt, bus.datagnt}), 32'd0);
      chk("rst_tx", 32'({bus.txvalid, bus.txsof, bus.txeof, bus.aborterr}), 32'd0);
      chk("rst_ready", 32'({bus.arpready, bus.dhcpready, bus.dataready}), 32'd0);

      // ARP beats data at reset release, then a 4-beat frame.
      tick();
      reset = 1'b1;
      tick();
      chk("arb_arp_src", 32'(bus.txsrc), 32'd1);
      chk("arb_arp_gnt", 32'({bus.arpgnt, bus.dhcpgnt, bus.datagnt}), 32'b100);
      chk("arb_arp_ready", 32'({bus.arpready, bus.dataready}), 32'b10);
      for (int i = 0; i < 4; i++) begin
         drive(1, 1'b1, i == 0, i == 3, 16'hA000 + 16'(i));
         #1;
         chk("arp4_beat", 32'({bus.txvalid, bus.txsof, bus.txeof}),
             32'({1'b1, i == 0, i == 3}));
         chk("arp4_data", 32'(bus.txdata), 32'h0000A000 + 32'(i));
         tick();
      end
      drive(1, 1'b0, 1'b0, 1'b0, 16'h0000);
      bus.arpreq = 1'b0;
      chk("arp4_gnt_drop", 32'({bus.arpgnt, bus.txvalid}), 32'd0);
      ok = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         ok = ok && (bus.txsrc == 2'd0);
      end
      chk("ifg_no_grant", 32'(ok), 32'd1);
      tick();
      chk("data_after_ifg", 32'(bus.txsrc), 32'd3);
      chk("data_gnt", 32'(bus.datagnt), 32'd1);

      // 8-beat data frame with txready toggling 1-0-1-0.
      sent = 0; cyc = 0; mirror_ok = 1'b1; order_ok = 1'b1;
      while (sent < 8 && cyc < 40) begin
         bus.txready = (cyc % 2 == 0);
         drive(3, 1'b1, sent == 0, sent == 7, 16'hD000 + 16'(sent));
         #1;
         mirror_ok = mirror_ok && (bus.dataready === bus.txready);
         if (bus.txready) begin
            order_ok = order_ok && bus.txvalid && (bus.txdata == 16'hD000 + 16'(sent))
                       && (bus.txsof == (sent == 0)) && (bus.txeof == (sent == 7));
            sent++;
         end
         tick();
         cyc++;
      end
      chk("bp_beats", 32'(sent), 32'd8);
      chk("bp_cycles", 32'(cyc), 32'd15);
      chk("bp_ready_mirror", 32'(mirror_ok), 32'd1);
      chk("bp_order", 32'(order_ok), 32'd1);
      chk("bp_gnt_drop", 32'(bus.txsrc), 32'd0);
      drive(3, 1'b0, 1'b0, 1'b0, 16'h0000);
      bus.txready = 1'b1;

      // Starvation guard: data passed over four times, then wins against ARP.
      for (int f = 0; f < 4; f++) begin
         bus.datareq = 1'b1;
         if (f % 2 == 0) bus.arpreq = 1'b1;
         else            bus.dhcpreq = 1'b1;
         wait_grant((f % 2 == 0) ? 2'd1 : 2'd2, "starve_ctl_grant");
         single((f % 2 == 0) ? 1 : 2, 16'h3000 + 16'(f), "starve_ctl");
         bus.arpreq = 1'b0;
         bus.dhcpreq = 1'b0;
      end
      bus.arpreq = 1'b1;
      wait_grant(2'd3, "starve_data_wins");
      single(3, 16'h3C3C, "starve_data");
      wait_grant(2'd1, "starve_cleared_arp");
      single(1, 16'h3D3D, "starve_arp");
      bus.arpreq = 1'b0;
      bus.datareq = 1'b0;

      // DHCP granted but silent: abort after 255 WAITSOF cycles.
      bus.dhcpreq = 1'b1;
      wait_grant(2'd2, "to_grant");
      ok = 1'b1;
      for (int n = 0; n < 254; n++) begin
         ok = ok && (bus.aborterr == 1'b0) && (bus.dhcpgnt == 1'b1);
         tick();
      end
      chk("to_wait_quiet", 32'(ok), 32'd1);
      chk("to_last_wait", 32'({bus.dhcpgnt, bus.aborterr}), 32'b10);
      tick();
      chk("to_abort_pulse", 32'({bus.aborterr, bus.dhcpgnt, bus.txsrc}), 32'b1000);
      tick();
      chk("to_abort_once", 32'(bus.aborterr), 32'd0);
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         ok = ok && (bus.txsrc == 2'd0);
      end
      chk("to_gap_idle", 32'(ok), 32'd1);
      tick();
      chk("to_rearb", 32'(bus.txsrc), 32'd2);
      drive(2, 1'b1, 1'b0, 1'b0, 16'hBEEF);
      #1;
      chk("drop_nosof", 32'({bus.txvalid, bus.dhcpready}), 32'b01);
      tick();
      single(2, 16'h2222, "dhcp_single");
      bus.dhcpreq = 1'b0;

      // Asynchronous reset in the middle of an ARP frame.
      bus.arpreq = 1'b1;
      wait_grant(2'd1, "rst_grant");
      drive(1, 1'b1, 1'b1, 1'b0, 16'h5000);
      tick();
      drive(1, 1'b1, 1'b0, 1'b0, 16'h5001);
      #1;
      chk("rst_xfer_valid", 32'({bus.txvalid, bus.txdata}), 32'h00015001);
      reset = 1'b0;
      #1;
      chk("rst_async_tx", 32'({bus.txvalid, bus.txsof, bus.txeof, bus.txdata}), 32'd0);
      chk("rst_async_gnt", 32'({bus.arpgnt, bus.arpready, bus.txsrc}), 32'd0);
      drive(1, 1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      reset = 1'b1;
      tick();
      chk("rst_rearb", 32'(bus.txsrc), 32'd1);
      single(1, 16'h1111, "arp_single");
      bus.arpreq = 1'b0;

      repeat (8) tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Transmit-side arbiter that shares the single Ethernet transmit framing path between three frame sources: the ARP responder, the DHCP client and the application UDP data sender. It grants the path to one source at a time on whole-frame boundaries, forwards the granted 16-bit stream with backpressure, enforces a minimum idle gap between frames, and recovers from a granted source that never starts its frame. ARP has fixed priority over DHCP over data, with a starvation guard for data.

## Interface
Parameters:
- IFG, 6: idle cycles inserted after each frame (0 treated as 1)
- SOFTIMEOUT, 255: cycles a grantee may take to present its sof beat before the grant is revoked
- STARVEMAX, 4: consecutive ARP/DHCP frames allowed while data is requesting; range 1-15

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs immediately
- arpreq, dhcpreq, datareq  in  1 each  frame-pending request per source, level
- arpgnt, dhcpgnt, datagnt  out  1 each  grant, one-hot or all zero
- arpvalid, dhcpvalid, datavalid  in  1 each  source beat valid
- arpsof, dhcpsof, datasof  in  1 each  first beat of frame
- arpeof, dhcpeof, dataeof  in  1 each  last beat of frame
- arpdata, dhcpdata, datadata  in  16 each  source beat
- arpready, dhcpready, dataready  out  1 each  beat accepted when valid & ready
- txvalid  out  1  beat valid to framer
- txsof, txeof  out  1 each  frame delimiters to framer
- txdata  out  16  beat to framer
- txready  in  1  framer can accept beat
- txsrc  out  2  granted source: 0 none, 1 ARP, 2 DHCP, 3 data
- aborterr  out  1  one-cycle pulse on SOFTIMEOUT revocation

## Operation
- States: IDLE, WAITSOF, XFER, GAP. Reset -> IDLE; all grants, ready, tx* outputs, txsrc, aborterr, counters = 0.
- IDLE: if any req high, choose winner: data if datareq & starvecnt==STARVEMAX, else ARP > DHCP > data. Register grant and txsrc, go WAITSOF. No req: stay.
- starvecnt (4 bits, saturating): on each ARP/DHCP grant with datareq high, +1; cleared on data grant or when datareq low at arbitration.
- WAITSOF: Xready = txready for granted source. Accepted beat with sof: forwarded with txsof=1; go XFER, or GAP if eof also set (single-beat frame). Accepted beat without sof: consumed and dropped, txvalid=0. timeout counter +1 per WAITSOF cycle; at SOFTIMEOUT with no sof accepted: aborterr pulse, grant cleared, go GAP.
- XFER: txvalid = Xvalid, txdata = Xdata, txeof = Xeof, txsof = 0 (sof from source ignored), Xready = txready. Accepted eof beat -> GAP, grant cleared on that edge. Deassertion of req mid-frame ignored; frame runs to eof.
- GAP: tx outputs 0, all ready 0, grants 0, txsrc 0; count max(IFG,1) cycles then IDLE.
- Non-granted sources always see ready=0; their valid is ignored.
- Forward path (valid/data/sof/eof to tx*, txready to Xready) is combinational through the grant mux; no data buffering.

## Timing
- Arbitration latency: req sampled in IDLE at edge N; grant high from N+1. First beat may transfer in the cycle grant is high.
- Minimum frame-to-frame spacing: eof accept at edge E, GAP cycles E+1..E+IFG, IDLE at E+IFG+1, next grant at E+IFG+2.
- aborterr high exactly one cycle, the cycle after the SOFTIMEOUT-th WAITSOF cycle.
- txready low stalls a beat indefinitely; no timeout in XFER.
- Reset asserted mid-frame: all outputs 0 asynchronously; framer sees truncated frame with no txeof (framer must discard).

## Test plan
- ARP and data req together at reset release -> ARP granted (txsrc=1), 4-beat frame forwarded with txsof on beat 0, txeof on beat 3, then 6 idle cycles, then data granted (txsrc=3).
- datareq held while ARP/DHCP alternate 10 frames -> data granted after the 4th ARP/DHCP frame; starvecnt cleared.
- DHCP granted, never asserts valid -> after 255 WAITSOF cycles aborterr pulses once, dhcpgnt drops, IFG gap, re-arbitration.
- txready toggled 1-0-1-0 during 8-beat data frame -> every beat forwarded exactly once, order preserved, dataready mirrors txready.
- Single-beat frame (sof & eof) from ARP -> one tx beat with txsof=txeof=1, GAP entered next edge.
- reset low mid-XFER -> all outputs 0 same cycle; after release, IDLE and fresh arbitration.
